// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet layer sequencer: state encoding, layer
// indices and default timing parameters.
package lenet_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LAUNCH = ST_LAUNCH,
    S_RUN    = ST_RUN,
    S_GAP    = ST_GAP,
    S_DONE   = ST_DONE,
    S_ERR    = ST_ERR
  } sched_state_t;

  localparam int L_CONV1 = 0;
  localparam int L_POOL1 = 1;
  localparam int L_CONV2 = 2;
  localparam int L_POOL2 = 3;
  localparam int L_FC1   = 4;
  localparam int L_FC2   = 5;

  localparam int DEF_GAP_CYCLES = 2;
  localparam int DEF_TIMEOUT    = 200000;

endpackage

// File: rtl/sched_watchdog.sv
// Per-layer watchdog: cleared on load, counts while enabled, flags expiry
// once the count reaches TIMEOUT-1 and then holds there.
module sched_watchdog #(
  parameter int TIMEOUT = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] r_cnt;

  assign o_expire = (r_cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lenet_layer_sched.sv
// Layer sequencer: launches each engine in turn with a level enable, inserts
// a low gap between layers, ping-pongs the feature-map bank, guards each layer.
module lenet_layer_sched
  import lenet_pkg::*;
#(
  parameter int N_LAYERS   = 6,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [N_LAYERS-1:0] layer_finish,
  output logic [N_LAYERS-1:0] layer_en,
  output logic                fm_bank_sel,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2:0]          err_layer,
  output logic [2:0]          cur_layer,
  output logic [CNT_W-1:0]    run_cycles,
  output logic [2:0]          dbg_state
);

  // Handshake: the engine enable is a level held from launch until the engine's
  // finish level is seen; it then drops for GAP_CYCLES+1 cycles so engines re-arm.

  sched_state_t          r_state, w_state_nxt;
  logic [N_LAYERS-1:0]   r_layer_en, w_layer_en_nxt;
  logic                  r_bank, w_bank_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;
  logic [2:0]            r_err_layer, w_err_layer_nxt;
  logic [2:0]            r_cur_layer, w_cur_nxt;
  logic [3:0]            r_gap_cnt, w_gap_nxt;
  logic [CNT_W-1:0]      r_run_cycles;
  logic                  w_run_clr;
  logic                  w_wd_load;
  logic                  w_wd_en;
  logic                  w_wd_expire;
  logic                  w_fin;

  // Enable is one-hot on the active layer, so masking ignores other finishes.
  assign w_fin = |(layer_finish & r_layer_en);

  sched_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_wd_load),
    .i_en    (w_wd_en),
    .o_expire(w_wd_expire)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_layer_en_nxt  = r_layer_en;
    w_bank_nxt      = r_bank;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_err_nxt       = r_err;
    w_err_layer_nxt = r_err_layer;
    w_cur_nxt       = r_cur_layer;
    w_gap_nxt       = r_gap_cnt;
    w_run_clr       = 1'b0;
    w_wd_load       = 1'b0;
    w_wd_en         = 1'b0;

    if (abort) begin
      w_state_nxt    = S_IDLE;
      w_layer_en_nxt = '0;
      w_busy_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ERR: begin
          if (start) begin
            w_state_nxt = S_LAUNCH;
            w_cur_nxt   = 3'(L_CONV1);
            w_bank_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
            w_busy_nxt  = 1'b1;
            w_run_clr   = 1'b1;
          end
        end
        S_LAUNCH: begin
          w_layer_en_nxt = N_LAYERS'(1) << r_cur_layer;
          w_wd_load      = 1'b1;
          w_state_nxt    = S_RUN;
        end
        S_RUN: begin
          w_wd_en = 1'b1;
          if (w_fin) begin
            w_layer_en_nxt = '0;
            w_cur_nxt      = r_cur_layer + 3'd1;
            w_bank_nxt     = ~r_bank;
            w_gap_nxt      = '0;
            w_state_nxt    = S_GAP;
          end else if (w_wd_expire) begin
            w_layer_en_nxt  = '0;
            w_err_nxt       = 1'b1;
            w_err_layer_nxt = r_cur_layer;
            w_busy_nxt      = 1'b0;
            w_state_nxt     = S_ERR;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 4'(GAP_CYCLES - 1)) begin
            if (r_cur_layer == 3'(N_LAYERS)) begin
              w_state_nxt = S_DONE;
              w_cur_nxt   = 3'(L_CONV1);
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_LAUNCH;
            end
          end else begin
            w_gap_nxt = r_gap_cnt + 4'd1;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt    = S_IDLE;
          w_layer_en_nxt = '0;
          w_busy_nxt     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_layer_en   <= '0;
      r_bank       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_layer  <= '0;
      r_cur_layer  <= '0;
      r_gap_cnt    <= '0;
      r_run_cycles <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_layer_en  <= w_layer_en_nxt;
      r_bank      <= w_bank_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_err_layer <= w_err_layer_nxt;
      r_cur_layer <= w_cur_nxt;
      r_gap_cnt   <= w_gap_nxt;
      // Counts every busy cycle and stays frozen once busy drops.
      if (w_run_clr) begin
        r_run_cycles <= '0;
      end else if (r_busy && (r_run_cycles != '1)) begin
        r_run_cycles <= r_run_cycles + 1'b1;
      end
    end
  end

  assign layer_en    = r_layer_en;
  assign fm_bank_sel = r_bank;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign err_layer   = r_err_layer;
  assign cur_layer   = r_cur_layer;
  assign run_cycles  = r_run_cycles;
  assign dbg_state   = r_state;

endmodule
